// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1 : 4-to-1 data selector with an optional output register.
//
// Routes one of four WIDTH-bit inputs to F. The two select bits form
// {sel1, sel2} with sel1 as the MSB:
//   00 -> A, 01 -> B, 10 -> C, 11 -> D
// sel_onehot reports the decoded select as {D,C,B,A} and always has the same
// timing as F.
//
// Parameters
//   WIDTH        : width of A, B, C, D and F (>= 1)
//   REGISTER_OUT : 1 -> F and sel_onehot are registered (1-cycle latency,
//                       synchronous active-high rst, load enable en)
//                  0 -> F and sel_onehot are purely combinational;
//                       clk, rst and en are ignored
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (wins over en)
//   en         in   1      load enable for the output registers
//   A, B, C, D in   WIDTH  data inputs 0..3
//   sel1       in   1      select MSB
//   sel2       in   1      select LSB
//   F          out  WIDTH  selected data
//   sel_onehot out  4      decoded select {D,C,B,A}
//
// Interface timing: there is no handshake. In registered mode every edge
// with en=1 (and rst=0) captures the current selection, so a new input can
// be presented every cycle. With en=0 the outputs hold their last value.
// -----------------------------------------------------------------------------
module mux_4x1 #(
   parameter int WIDTH        = 1,
   parameter int REGISTER_OUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic             sel1,
   input  logic             sel2,
   output logic [WIDTH-1:0] F,
   output logic [3:0]       sel_onehot
);

   // Combinational selection shared by both output modes.
   logic [WIDTH-1:0] sel_data;
   logic [3:0]       sel_dec;

   always_comb begin
      sel_data = '0;
      sel_dec  = 4'b0000;
      case ({sel1, sel2})
         2'b00: begin
            sel_data = A;
            sel_dec  = 4'b0001;
         end
         2'b01: begin
            sel_data = B;
            sel_dec  = 4'b0010;
         end
         2'b10: begin
            sel_data = C;
            sel_dec  = 4'b0100;
         end
         2'b11: begin
            sel_data = D;
            sel_dec  = 4'b1000;
         end
         default: begin
            // An unknown select must not quietly pick an input: propagate X
            // so a floating select is visible downstream in simulation.
            sel_data = {WIDTH{1'bx}};
            sel_dec  = 4'bxxxx;
         end
      endcase
   end

   generate
      if (REGISTER_OUT != 0) begin : g_reg
         logic [WIDTH-1:0] f_q;
         logic [3:0]       onehot_q;

         // rst has priority over en so a reset edge always clears the outputs.
         always_ff @(posedge clk) begin
            if (rst) begin
               f_q      <= '0;
               onehot_q <= 4'b0000;
            end else if (en) begin
               f_q      <= sel_data;
               onehot_q <= sel_dec;
            end
         end

         assign F          = f_q;
         assign sel_onehot = onehot_q;
      end else begin : g_comb
         // Clock, reset and enable have no function in this mode; fold them
         // into a sink so they are visibly consumed.
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst, en};

         assign F          = sel_data;
         assign sel_onehot = sel_dec;
      end
   endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1 : scoreboard bench for mux_4x1.
//
// Three instances share one clock:
//   u_w1 : WIDTH=1, registered
//   u_w8 : WIDTH=8, registered
//   u_wc : WIDTH=8, combinational (same inputs as u_w8)
// Inputs are driven 1 time unit after each rising edge. Expected responses
// are stamped with the cycle in which they must appear: the registered
// instances one cycle later, the combinational instance in the same cycle.
// A monitor on the falling edge pops and compares entries whose stamp is due.
// -----------------------------------------------------------------------------
module tb_mux_4x1;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  f;
      logic [3:0]  oh;
      logic [7:0]  id;
   } exp_t;

   // Clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // WIDTH=1 instance signals
   logic       rst1, en1, a1, b1, c1, d1, s1_1, s2_1;
   logic       f1;
   logic [3:0] oh1;

   // WIDTH=8 instances (registered and combinational) share these inputs
   logic       rst8, en8, s1_8, s2_8;
   logic [7:0] a8, b8, c8, d8;
   logic [7:0] f8, fc;
   logic [3:0] oh8, ohc;

   mux_4x1 #(.WIDTH(1), .REGISTER_OUT(1)) u_w1 (
      .clk(clk), .rst(rst1), .en(en1),
      .A(a1), .B(b1), .C(c1), .D(d1),
      .sel1(s1_1), .sel2(s2_1),
      .F(f1), .sel_onehot(oh1)
   );

   mux_4x1 #(.WIDTH(8), .REGISTER_OUT(1)) u_w8 (
      .clk(clk), .rst(rst8), .en(en8),
      .A(a8), .B(b8), .C(c8), .D(d8),
      .sel1(s1_8), .sel2(s2_8),
      .F(f8), .sel_onehot(oh8)
   );

   mux_4x1 #(.WIDTH(8), .REGISTER_OUT(0)) u_wc (
      .clk(clk), .rst(rst8), .en(en8),
      .A(a8), .B(b8), .C(c8), .D(d8),
      .sel1(s1_8), .sel2(s2_8),
      .F(fc), .sel_onehot(ohc)
   );

   // Scoreboard
   exp_t q1[$];
   exp_t q8[$];
   exp_t qc[$];
   int tests_run    = 0;
   int tests_failed = 0;
   logic [7:0] next_id = 8'd0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic r, input logic e, input logic [3:0] abcd,
                         input logic [1:0] sel);
      rst1 = r; en1 = e;
      a1 = abcd[3]; b1 = abcd[2]; c1 = abcd[1]; d1 = abcd[0];
      {s1_1, s2_1} = sel;
   endtask

   task automatic exp1(input logic f, input logic [3:0] oh);
      exp_t e;
      e.cyc = cyc + 32'd1; e.f = {7'd0, f}; e.oh = oh; e.id = next_id;
      next_id = next_id + 8'd1;
      q1.push_back(e);
   endtask

   task automatic drive8(input logic r, input logic e, input logic [1:0] sel);
      rst8 = r; en8 = e;
      {s1_8, s2_8} = sel;
   endtask

   task automatic exp8(input logic [7:0] f, input logic [3:0] oh);
      exp_t e;
      e.cyc = cyc + 32'd1; e.f = f; e.oh = oh; e.id = next_id;
      next_id = next_id + 8'd1;
      q8.push_back(e);
   endtask

   task automatic expc(input logic [7:0] f, input logic [3:0] oh);
      exp_t e;
      e.cyc = cyc; e.f = f; e.oh = oh; e.id = next_id;
      next_id = next_id + 8'd1;
      qc.push_back(e);
   endtask

   // Monitor: compare every entry due in this cycle; an entry whose cycle has
   // already passed was never checked and counts as a failure.
   always @(negedge clk) begin
      exp_t e;
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
         e = q1.pop_front();
         tests_run++;
         if (e.cyc != cyc || f1 !== e.f[0] || oh1 !== e.oh) begin
            tests_failed++;
            $display("FAIL w1 id=%0d cyc=%0d: F=%b oh=%b, expected F=%b oh=%b",
                     e.id, cyc, f1, oh1, e.f[0], e.oh);
         end
      end
      while (q8.size() > 0 && q8[0].cyc <= cyc) begin
         e = q8.pop_front();
         tests_run++;
         if (e.cyc != cyc || f8 !== e.f || oh8 !== e.oh) begin
            tests_failed++;
            $display("FAIL w8 id=%0d cyc=%0d: F=%h oh=%b, expected F=%h oh=%b",
                     e.id, cyc, f8, oh8, e.f, e.oh);
         end
      end
      while (qc.size() > 0 && qc[0].cyc <= cyc) begin
         e = qc.pop_front();
         tests_run++;
         if (e.cyc != cyc || fc !== e.f || ohc !== e.oh) begin
            tests_failed++;
            $display("FAIL comb id=%0d cyc=%0d: F=%h oh=%b, expected F=%h oh=%b",
                     e.id, cyc, fc, ohc, e.f, e.oh);
         end
      end
   end

   // Stimulus; abcd is {A,B,C,D}
   initial begin
      drive1(1'b1, 1'b1, 4'b0000, 2'b00);
      a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
      drive8(1'b1, 1'b1, 2'b00);
      step();

      // ---- WIDTH=1: reset for 2 cycles with A=1 ----
      drive1(1'b1, 1'b1, 4'b1000, 2'b00); exp1(1'b0, 4'b0000); step();
      drive1(1'b1, 1'b1, 4'b1000, 2'b00); exp1(1'b0, 4'b0000); step();
      // release: follows select on next edge
      drive1(1'b0, 1'b1, 4'b1000, 2'b00); exp1(1'b1, 4'b0001); step();

      // ---- select sweep with one-hot data ----
      drive1(1'b0, 1'b1, 4'b0100, 2'b01); exp1(1'b1, 4'b0010); step();
      drive1(1'b0, 1'b1, 4'b0010, 2'b10); exp1(1'b1, 4'b0100); step();
      drive1(1'b0, 1'b1, 4'b0001, 2'b11); exp1(1'b1, 4'b1000); step();
      // one-hot data not on the selected input -> 0
      drive1(1'b0, 1'b1, 4'b0111, 2'b00); exp1(1'b0, 4'b0001); step();

      // ---- isolation: sel=10, C=0, others toggle ----
      drive1(1'b0, 1'b1, 4'b1101, 2'b10); exp1(1'b0, 4'b0100); step();
      drive1(1'b0, 1'b1, 4'b0000, 2'b10); exp1(1'b0, 4'b0100); step();
      drive1(1'b0, 1'b1, 4'b1001, 2'b10); exp1(1'b0, 4'b0100); step();
      drive1(1'b0, 1'b1, 4'b0100, 2'b10); exp1(1'b0, 4'b0100); step();

      // ---- hold ----
      drive1(1'b0, 1'b1, 4'b1000, 2'b00); exp1(1'b1, 4'b0001); step();
      drive1(1'b0, 1'b0, 4'b0000, 2'b00); exp1(1'b1, 4'b0001); step();
      drive1(1'b0, 1'b0, 4'b0000, 2'b11); exp1(1'b1, 4'b0001); step();
      drive1(1'b0, 1'b1, 4'b0000, 2'b11); exp1(1'b0, 4'b1000); step();

      // ---- reset mid-operation, rst wins over en=0 ----
      drive1(1'b0, 1'b1, 4'b0001, 2'b11); exp1(1'b1, 4'b1000); step();
      drive1(1'b1, 1'b0, 4'b0001, 2'b11); exp1(1'b0, 4'b0000); step();
      drive1(1'b0, 1'b0, 4'b0001, 2'b11); exp1(1'b0, 4'b0000); step();
      drive1(1'b0, 1'b1, 4'b0001, 2'b11); exp1(1'b1, 4'b1000); step();

      // ---- WIDTH=8 registered + combinational ----
      drive8(1'b1, 1'b1, 2'b00); exp8(8'h00, 4'b0000); expc(8'h11, 4'b0001); step();
      drive8(1'b0, 1'b1, 2'b00); exp8(8'h11, 4'b0001); expc(8'h11, 4'b0001); step();
      drive8(1'b0, 1'b1, 2'b01); exp8(8'h22, 4'b0010); expc(8'h22, 4'b0010); step();
      drive8(1'b0, 1'b1, 2'b10); exp8(8'h33, 4'b0100); expc(8'h33, 4'b0100); step();
      drive8(1'b0, 1'b1, 2'b11); exp8(8'h44, 4'b1000); expc(8'h44, 4'b1000); step();
      // en=0: registered holds, combinational follows
      drive8(1'b0, 1'b0, 2'b01); exp8(8'h44, 4'b1000); expc(8'h22, 4'b0010); step();
      // rst=1: registered clears, combinational unaffected
      drive8(1'b1, 1'b0, 2'b10); exp8(8'h00, 4'b0000); expc(8'h33, 4'b0100); step();
      // bit-mixed data to show bitwise-uniform selection
      a8 = 8'hA5; b8 = 8'h5A; c8 = 8'hF0; d8 = 8'h0F;
      drive8(1'b0, 1'b1, 2'b10); exp8(8'hF0, 4'b0100); expc(8'hF0, 4'b0100); step();
      drive8(1'b0, 1'b1, 2'b01); exp8(8'h5A, 4'b0010); expc(8'h5A, 4'b0010); step();
      drive8(1'b0, 1'b1, 2'b00); exp8(8'hA5, 4'b0001); expc(8'hA5, 4'b0001); step();

      // Drain, bounded
      for (int i = 0; i < 10; i++) begin
         if (q1.size() == 0 && q8.size() == 0 && qc.size() == 0) break;
         step();
      end
      if (q1.size() + q8.size() + qc.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d expected entries never checked, required 0",
                  q1.size() + q8.size() + qc.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
